// File: rtl/pwm_pkg.sv
// Shared constants for the PWM output stage: counter width, full-scale duty,
// default prescale and channel count.
package pwm_pkg;
  localparam int         PWM_CNT_W        = 8;
  localparam logic [7:0] PWM_DUTY_FULL    = 8'hFF;
  localparam int         PWM_PRESCALE_DEF = 12;
  localparam int         PWM_NCH          = 16;
  localparam int         PWM_PRESC_W      = 12;
endpackage

// File: rtl/pwm_prescaler.sv
// Free-running 0..PRESCALE-1 divider; tick is high while the count sits on
// its terminal value, so PRESCALE = 1 yields a tick every cycle.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int PRESCALE = PWM_PRESCALE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [PWM_PRESC_W-1:0] TERM = PWM_PRESC_W'(PRESCALE - 1);

  logic [PWM_PRESC_W-1:0] presc_q;
  logic [PWM_PRESC_W-1:0] presc_d;

  assign tick    = (presc_q == TERM);
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/pwm_output_stage.sv
// 16-channel PWM/static output stage sharing one prescaled 8-bit timebase.
// Define PWM_SHADOW_EN to latch the duty only at period boundaries.
module pwm_output_stage
  import pwm_pkg::*;
#(
  parameter int PRESCALE = PWM_PRESCALE_DEF,
  parameter int CNT_W    = PWM_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           en_reg_out_7_0,
  input  logic [7:0]           en_reg_out_15_8,
  input  logic [7:0]           en_reg_pwm_7_0,
  input  logic [7:0]           en_reg_pwm_15_8,
  input  logic [7:0]           pwm_duty_cycle,
  output logic [PWM_NCH-1:0]   out,
  output logic                 period_start
);

  logic               tick;
  logic               wrap;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [CNT_W-1:0]   duty_eff;
  logic               pwm_sig;
  logic [PWM_NCH-1:0] en_out;
  logic [PWM_NCH-1:0] en_pwm;
  logic [PWM_NCH-1:0] out_q;
  logic [PWM_NCH-1:0] out_d;

  pwm_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign wrap  = tick && (cnt_q == '1);
  assign cnt_d = tick ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef PWM_SHADOW_EN
  // load_q forces one capture on the first clock out of reset so the shadow
  // does not sit at 0 for a whole period.
  logic [CNT_W-1:0] duty_q;
  logic             load_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= '0;
      load_q <= 1'b1;
    end else begin
      load_q <= 1'b0;
      if (load_q || wrap) begin
        duty_q <= pwm_duty_cycle;
      end
    end
  end

  assign duty_eff = duty_q;
`else
  assign duty_eff = pwm_duty_cycle;
`endif

  assign pwm_sig = (duty_eff == PWM_DUTY_FULL) || (cnt_q < duty_eff);

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign out_d  = en_out & (pwm_sig ? {PWM_NCH{1'b1}} : ~en_pwm);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out          = out_q;
  assign period_start = wrap;

endmodule
